// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: funct3 codes, FSM states,
// byte-enable patterns and the access-size helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Bytes touched by an access; only funct3[1:0] carries the size.
    function automatic logic [2:0] acc_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data extractor: picks the low byte/half/word of the raw memory word
// and sign- or zero-extends it according to funct3. Purely combinational.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'b0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of dataMem; all memory-side outputs are flops.
// Latency from acceptance: error 1, store 2, load 3 cycles; one request in flight.
// Response held until rsp_ready; req_ready only in IDLE. LSU_MISALIGN_TRAP_EN traps misaligned H/W.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,
    output logic [SIZE-1:0] mem_addr,
    output logic [31:0]     mem_dataW,
    output logic [3:0]      mem_wrType,
    output logic            mem_memR,
    input  logic [31:0]     mem_dataR
);

    state_e          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]     mem_dataW_q, mem_dataW_d;
    logic [3:0]      mem_wrType_q, mem_wrType_d;
    logic            mem_memR_q, mem_memR_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            f3_legal;
    logic            out_of_range;
    logic            acc_err;
    logic [2:0]      bytes_m1;
    logic [SIZE:0]   end_addr;
    logic [3:0]      store_be;
    logic [31:0]     store_data;
    logic [31:0]     load_data;

    lsu_load_ext u_load_ext (
        .funct3 (f3_q),
        .raw    (mem_dataR),
        .ext    (load_data)
    );

    // Request legality: funct3 decode, range (no wrap past the top byte), alignment.
    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !req_we;
            default:          f3_legal = 1'b0;
        endcase

        bytes_m1     = acc_bytes(req_funct3) - 3'd1;
        end_addr     = {1'b0, req_addr[SIZE-1:0]} + {{(SIZE-2){1'b0}}, bytes_m1};
        out_of_range = (req_addr[31:SIZE] != '0) || end_addr[SIZE];

`ifdef LSU_MISALIGN_TRAP_EN
        acc_err = !f3_legal || out_of_range
                  || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        acc_err = !f3_legal || out_of_range;
`endif
    end

    always_comb begin
        store_be   = BE_W;
        store_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                store_be   = BE_B;
                store_data = {24'b0, req_wdata[7:0]};
            end
            2'b01: begin
                store_be   = BE_H;
                store_data = {16'b0, req_wdata[15:0]};
            end
            default: begin
                store_be   = BE_W;
                store_data = req_wdata;
            end
        endcase
    end

    // The memory strobes are loaded on the acceptance edge so they are already
    // registered during WRITE/READ, and cleared on the edge that leaves them.
    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        mem_addr_d   = mem_addr_q;
        mem_dataW_d  = mem_dataW_q;
        mem_wrType_d = 4'b0000;
        mem_memR_d   = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d        = req_funct3;
                    rsp_rdata_d = 32'b0;
                    rsp_err_d   = acc_err;
                    if (acc_err) begin
                        state_d = RESP;
                    end else if (req_we) begin
                        state_d      = WRITE;
                        mem_addr_d   = req_addr[SIZE-1:0];
                        mem_dataW_d  = store_data;
                        mem_wrType_d = store_be;
                    end else begin
                        state_d    = READ;
                        mem_addr_d = req_addr[SIZE-1:0];
                        mem_memR_d = 1'b1;
                    end
                end
            end
            WRITE: state_d = RESP;
            READ:  state_d = WAIT;
            WAIT: begin
                rsp_rdata_d = load_data;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            f3_q         <= 3'b000;
            mem_addr_q   <= '0;
            mem_dataW_q  <= 32'b0;
            mem_wrType_q <= 4'b0000;
            mem_memR_q   <= 1'b0;
            rsp_rdata_q  <= 32'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            mem_addr_q   <= mem_addr_d;
            mem_dataW_q  <= mem_dataW_d;
            mem_wrType_q <= mem_wrType_d;
            mem_memR_q   <= mem_memR_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_dataW  = mem_dataW_q;
    assign mem_wrType = mem_wrType_q;
    assign mem_memR   = mem_memR_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model (byte i preset to i[7:0]).
module tb_lsu_ctrl;

    localparam int SIZE = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [SIZE-1:0] mem_addr;
    logic [31:0]     mem_dataW;
    logic [3:0]      mem_wrType;
    logic            mem_memR;
    logic [31:0]     mem_dataR;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_ctrl #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_dataW  (mem_dataW),
        .mem_wrType (mem_wrType),
        .mem_memR   (mem_memR),
        .mem_dataR  (mem_dataR)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];
    logic       mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
            mem_init_done <= 1'b1;
            mem_dataR     <= 32'b0;
        end else begin
            if (mem_wrType[0]) mem[mem_addr]         <= mem_dataW[7:0];
            if (mem_wrType[1]) mem[mem_addr + 12'd1] <= mem_dataW[15:8];
            if (mem_wrType[2]) mem[mem_addr + 12'd2] <= mem_dataW[23:16];
            if (mem_wrType[3]) mem[mem_addr + 12'd3] <= mem_dataW[31:24];
            if (mem_memR)
                mem_dataR <= {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                              mem[mem_addr + 12'd1], mem[mem_addr]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, time the response, then hold rsp_ready low for 'hold' cycles.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input string tag,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wr_cyc, output int rd_cyc,
                          output logic [3:0] be, output logic [31:0] wdat);
        int guard;
        int bad;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 32'hxxxxxxxx;
        req_wdata = 32'hxxxxxxxx;
        lat = 1; wr_cyc = 0; rd_cyc = 0; be = 4'b0; wdat = 32'b0;
        while (1) begin
            if (mem_wrType != 4'b0) begin
                wr_cyc++;
                be   = mem_wrType;
                wdat = mem_dataW;
            end
            if (mem_memR) rd_cyc++;
            if (rsp_valid || lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".rsp_seen"}, {31'b0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        bad   = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0
                || mem_wrType !== 4'b0 || mem_memR !== 1'b0)
                bad++;
        end
        if (hold > 0) chk({tag, ".hold_stable"}, bad, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdat, input int hold);
        int         lat, wr_cyc, rd_cyc, exp_lat;
        logic [31:0] rdata, wdat;
        logic        err;
        logic [3:0]  be;
        do_req(we, f3, addr, wdata, hold, tag, lat, rdata, err, wr_cyc, rd_cyc, be, wdat);
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        chk({tag, ".lat"},    lat, exp_lat);
        chk({tag, ".err"},    {31'b0, err}, {31'b0, exp_err});
        chk({tag, ".rdata"},  rdata, exp_rdata);
        chk({tag, ".wr_cyc"}, wr_cyc, (we && !exp_err) ? 1 : 0);
        chk({tag, ".rd_cyc"}, rd_cyc, (!we && !exp_err) ? 1 : 0);
        if (we && !exp_err) begin
            chk({tag, ".be"},   {28'b0, be}, {28'b0, exp_be});
            chk({tag, ".wdat"}, wdat, exp_wdat);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rsp_valid",  {31'b0, rsp_valid}, 32'd0);
        chk("rst.rsp_err",    {31'b0, rsp_err}, 32'd0);
        chk("rst.rsp_rdata",  rsp_rdata, 32'd0);
        chk("rst.mem_addr",   {20'b0, mem_addr}, 32'd0);
        chk("rst.mem_dataW",  mem_dataW, 32'd0);
        chk("rst.mem_wrType", {28'b0, mem_wrType}, 32'd0);
        chk("rst.mem_memR",   {31'b0, mem_memR}, 32'd0);
        chk("rst.req_ready",  {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // tag, we, f3, addr, wdata, exp_err, exp_rdata, exp_be, exp_wdat, hold
        xact("sw10",   1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 0);
        xact("lw10",   1'b0, 3'b010, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF, 4'h0, 32'h0,        0);
        xact("sb20",   1'b1, 3'b000, 32'h020, 32'hFFFFFF80, 1'b0, 32'h0,        4'h1, 32'h00000080, 0);
        xact("lb20",   1'b0, 3'b000, 32'h020, 32'h0,        1'b0, 32'hFFFFFF80, 4'h0, 32'h0,        0);
        xact("lbu20",  1'b0, 3'b100, 32'h020, 32'h0,        1'b0, 32'h00000080, 4'h0, 32'h0,        0);
        xact("lw20",   1'b0, 3'b010, 32'h020, 32'h0,        1'b0, 32'h23222180, 4'h0, 32'h0,        0);
        xact("sh30",   1'b1, 3'b001, 32'h030, 32'h1234ABCD, 1'b0, 32'h0,        4'h3, 32'h0000ABCD, 0);
        xact("lh30",   1'b0, 3'b001, 32'h030, 32'h0,        1'b0, 32'hFFFFABCD, 4'h0, 32'h0,        0);
        xact("lhu30",  1'b0, 3'b101, 32'h030, 32'h0,        1'b0, 32'h0000ABCD, 4'h0, 32'h0,        0);
        xact("lw30",   1'b0, 3'b010, 32'h030, 32'h0,        1'b0, 32'h3332ABCD, 4'h0, 32'h0,        0);
        xact("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0,       1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("lwffe",  1'b0, 3'b010, 32'hFFE, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("swffd",  1'b1, 3'b010, 32'hFFD, 32'h11111111, 1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("lbfff",  1'b0, 3'b000, 32'hFFF, 32'h0,        1'b0, 32'hFFFFFFFF, 4'h0, 32'h0,        0);
        xact("lhufff", 1'b0, 3'b101, 32'hFFF, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("badst",  1'b1, 3'b100, 32'h040, 32'h55555555, 1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("badld",  1'b0, 3'b110, 32'h040, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("hiaddr", 1'b0, 3'b000, 32'h8000_0010, 32'h0,  1'b1, 32'h0,        4'h0, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
        xact("lw11",   1'b0, 3'b010, 32'h011, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        xact("sh31",   1'b1, 3'b001, 32'h031, 32'h00009999, 1'b1, 32'h0,        4'h0, 32'h0,        0);
`else
        xact("lw11",   1'b0, 3'b010, 32'h011, 32'h0,        1'b0, 32'h14DEADBE, 4'h0, 32'h0,        0);
        xact("lh13",   1'b0, 3'b001, 32'h013, 32'h0,        1'b0, 32'h000014DE, 4'h0, 32'h0,        0);
`endif
        xact("bp_lw10", 1'b0, 3'b010, 32'h010, 32'h0,       1'b0, 32'hDEADBEEF, 4'h0, 32'h0,        5);
        chk("bp.req_ready_after", {31'b0, req_ready}, 32'd1);

        // Reset while the read strobe is out.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h030;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid.memR_before", {31'b0, mem_memR}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.memR",      {31'b0, mem_memR}, 32'd0);
        chk("rstmid.mem_addr",  {20'b0, mem_addr}, 32'd0);
        chk("rstmid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstmid.req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstmid.rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
        xact("post_rst_lw10", 1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the core's memory stage and the byte-addressed data memory (`dataMem`). It accepts one RV32 load/store request at a time over a valid/ready handshake and drives the memory's `addr`, `dataW`, `wrType` and `memR` from flops. It waits out the memory's one-cycle registered read, then extracts and sign/zero-extends load data. It returns a response with an error flag for illegal or out-of-range accesses.

Parameters:
SIZE, 12, memory address width; memory holds 2**SIZE bytes; must match the `dataMem` instance.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3 (size/sign)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access was rejected; no memory side effect
mem_addr  out  SIZE  to dataMem addr
mem_dataW  out  32  to dataMem dataW
mem_wrType  out  4  to dataMem byte write enables
mem_memR  out  1  to dataMem read enable
mem_dataR  in  32  from dataMem, valid the cycle after memR sampled

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_addr=0, mem_dataW=0, mem_wrType=0000, mem_memR=0.
  - Reset mid-operation abandons the access; any in-flight response is dropped.
- mem_wrType, mem_addr, mem_dataW, mem_memR come directly from flops (no combinational path). The memory write is level-sensitive, so glitches are forbidden.
- mem_wrType is nonzero for exactly one cycle per store.
- req_ready = (state==IDLE). Acceptance = req_valid & req_ready at a rising edge.
- Legal funct3:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other encoding is an error.
- Range check: error if req_addr[31:SIZE] != 0, or if addr[SIZE-1:0] + (bytes-1) > 2**SIZE-1. This forbids wrap at the top of memory.
- States:
  - IDLE: on acceptance:
    - error -> RESP with rsp_err=1;
    - store -> WRITE;
    - load -> READ.
    - Address, data, funct3 and we are latched.
  - WRITE: mem_addr=latched addr; mem_dataW = wdata masked to size (SB {24'b0,b}, SH {16'b0,h}, SW full); mem_wrType SB 0001, SH 0011, SW 1111. Next -> RESP.
  - READ: mem_memR=1, mem_addr=latched addr. Next -> WAIT.
  - WAIT: mem_memR=0. Sample mem_dataR:
    - LB sign-extends [7:0]; LBU zero-extends [7:0];
    - LH sign-extends [15:0]; LHU zero-extends [15:0];
    - LW takes all 32 bits.
    - Result registered into rsp_rdata. Next -> RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then -> IDLE.
- Latency, acceptance edge = T:
  - store rsp_valid high after T+2;
  - load after T+3;
  - error after T+1.
  - Back-to-back throughput: one request per (latency+1) cycles minimum.
- mem_addr and mem_dataW hold their last values outside WRITE/READ. mem_wrType is forced to 0000 in every state except WRITE.
- Between requests, req_addr, req_wdata, req_funct3 and req_we are don't-care.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, is an error. No memory access is made and rsp_err=1.
- Undefined: misaligned accesses proceed, since the memory is byte-granular. Only the funct3 and range checks apply.

Decomposition:
- Package lsu_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, WRITE, READ, WAIT, RESP);
  - the byte-enable constants (BE_B=0001, BE_H=0011, BE_W=1111);
  - a function returning access size in bytes from funct3.
- One natural sub-module: lsu_load_ext, a combinational funct3 + raw 32-bit data -> extended 32-bit result. It can be unit-tested on its own.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> wrType 1111 for exactly 1 cycle; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+3.
- SB 0x020 data 0x00000080, then LB 0x020 / LBU 0x020 -> 0xFFFFFF80 / 0x00000080; neighbouring bytes 0x021-0x023 unchanged.
- SH 0x030 data 0x1234ABCD, then LH / LHU 0x030 -> 0xFFFFABCD / 0x0000ABCD; wrType 0011.
- LW addr 0x1000 (SIZE=12), and LW 0xFFE -> rsp_err=1 at T+1; memR and wrType never asserted; rsp_rdata=0.
- LW 0x011: with LSU_MISALIGN_TRAP_EN -> rsp_err=1; without -> rsp_rdata = bytes 0x011-0x014, little-endian.
- Hold rsp_ready=0 for 5 cycles, then pulse it -> rsp fields stable, req_ready=0 throughout. Assert rst_n=0 during READ -> all outputs at reset values immediately; the next request completes normally.
